// File: rtl/regfile_ctrl_pkg.sv
// Shared constants, FSM encoding and decode helpers for the register-file
// access controller.
package regfile_ctrl_pkg;

  localparam int NREG_DEF = 8;
  localparam int W_DEF    = 16;
  localparam int AW_DEF   = 3;

  // Widest file the onehot helper can address; callers truncate to NREG.
  localparam int ONEHOT_MAX = 256;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_MOVE  = 2'b10;
  localparam logic [1:0] OP_SWAP  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WR1  = 3'd2,
    ST_WR2  = 3'd3,
    ST_RSP  = 3'd4
  } state_t;

  function automatic logic [ONEHOT_MAX-1:0] onehot(input logic [7:0] idx);
    logic [ONEHOT_MAX-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. A grant is only issued while enabled;
// on a tie the requester that did not win last time is chosen.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       enable,
  output logic [1:0] grant
);

  logic last_grant;

  // Pick a single winner; a lone requester always wins.
  always_comb begin
    grant = 2'b00;
    if (enable) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  // Remember the last winner; reset value 1 lets requester 0 take the first tie.
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_grant <= 1'b1;
    end else if (grant != 2'b00) begin
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/regfile_access_ctrl.sv
// Command sequencer for a load / dual-read register file shared by two
// requesters. Each accepted command yields exactly one response pulse.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | waiting for a command, arbiter enabled
//   RD    | A bus <- R[rs], B bus <- R[rd], captured into tmp_a/tmp_b
//   WR1   | load R[rd] with write data (WRITE) or tmp_a (MOVE/SWAP)
//   WR2   | load R[rs] with tmp_b (second half of SWAP)
//   RSP   | one-cycle response pulse to the owning requester
module regfile_access_ctrl
  import regfile_ctrl_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int W    = W_DEF,
  parameter int AW   = AW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [1:0]      req0_op,
  input  logic [AW-1:0]   req0_rd,
  input  logic [AW-1:0]   req0_rs,
  input  logic [W-1:0]    req0_data,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [1:0]      req1_op,
  input  logic [AW-1:0]   req1_rd,
  input  logic [AW-1:0]   req1_rs,
  input  logic [W-1:0]    req1_data,
  output logic            rsp_valid,
  output logic            rsp_id,
  output logic [W-1:0]    rsp_data,
  output logic            busy,
  output logic [NREG-1:0] rf_load,
  output logic [W-1:0]    rf_din,
  output logic [NREG-1:0] rf_oeA,
  output logic [NREG-1:0] rf_oeB,
  input  logic [W-1:0]    rf_dA,
  input  logic [W-1:0]    rf_dB
);

  state_t        state_q, state_d;
  logic [1:0]    op_q;
  logic [AW-1:0] rd_q, rs_q;
  logic [W-1:0]  data_q;
  logic          id_q;
  logic [W-1:0]  tmp_a, tmp_b;
  logic [W-1:0]  rsp_data_d;

  logic [1:0]    grant;
  logic          accept;
  logic [1:0]    acc_op;
  logic [AW-1:0] acc_rd, acc_rs;
  logic [W-1:0]  acc_data;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    ({req1_valid, req0_valid}),
    .enable (state_q == ST_IDLE),
    .grant  (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign accept     = grant[0] | grant[1];
  assign busy       = (state_q != ST_IDLE);

  // Mux the winning requester's command fields.
  always_comb begin
    acc_op   = grant[1] ? req1_op   : req0_op;
    acc_rd   = grant[1] ? req1_rd   : req0_rd;
    acc_rs   = grant[1] ? req1_rs   : req0_rs;
    acc_data = grant[1] ? req1_data : req0_data;
  end

  // Next state and register-file strobes; the bus is parked at zero when idle.
  always_comb begin
    state_d    = state_q;
    rf_load    = '0;
    rf_din     = '0;
    rf_oeA     = '0;
    rf_oeB     = '0;
    rsp_data_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = (acc_op == OP_WRITE) ? ST_WR1 : ST_RD;
      end
      ST_RD: begin
        rf_oeA     = NREG'(onehot(8'(rs_q)));
        rf_oeB     = NREG'(onehot(8'(rd_q)));
        rsp_data_d = rf_dA;
        state_d    = (op_q == OP_READ) ? ST_RSP : ST_WR1;
      end
      ST_WR1: begin
        rf_load    = NREG'(onehot(8'(rd_q)));
        rf_din     = (op_q == OP_WRITE) ? data_q : tmp_a;
        rsp_data_d = rf_din;
        state_d    = (op_q == OP_SWAP) ? ST_WR2 : ST_RSP;
      end
      ST_WR2: begin
        // Response for SWAP is the old R[rd], which is exactly tmp_b.
        rf_load    = NREG'(onehot(8'(rs_q)));
        rf_din     = tmp_b;
        rsp_data_d = tmp_b;
        state_d    = ST_RSP;
      end
      ST_RSP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, captured command, read temporaries and the registered response.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_WRITE;
      rd_q      <= '0;
      rs_q      <= '0;
      data_q    <= '0;
      id_q      <= 1'b0;
      tmp_a     <= '0;
      tmp_b     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q   <= acc_op;
        rd_q   <= acc_rd;
        rs_q   <= acc_rs;
        data_q <= acc_data;
        id_q   <= grant[1];
      end
      if (state_q == ST_RD) begin
        tmp_a <= rf_dA;
        tmp_b <= rf_dB;
      end
      rsp_valid <= (state_d == ST_RSP);
      if (state_d == ST_RSP) begin
        rsp_id   <= id_q;
        rsp_data <= rsp_data_d;
      end
    end
  end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench for regfile_access_ctrl: behavioural register file driven by the DUT
// strobes, plus an abstract command-level model of register contents.
module tb_regfile_access_ctrl;

  logic        clk;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [1:0]  req0_op, req1_op;
  logic [2:0]  req0_rd, req0_rs, req1_rd, req1_rs;
  logic [15:0] req0_data, req1_data;
  logic        rsp_valid, rsp_id;
  logic [15:0] rsp_data;
  logic        busy;
  logic [7:0]  rf_load, rf_oeA, rf_oeB;
  logic [15:0] rf_din, rf_dA, rf_dB;

  logic [15:0] phys [8] = '{default: 16'h0000};
  logic [15:0] mreg [8];

  int tests = 0;
  int fails = 0;

  regfile_access_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_rd    (req0_rd),
    .req0_rs    (req0_rs),
    .req0_data  (req0_data),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_rd    (req1_rd),
    .req1_rs    (req1_rs),
    .req1_data  (req1_data),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .busy       (busy),
    .rf_load    (rf_load),
    .rf_din     (rf_din),
    .rf_oeA     (rf_oeA),
    .rf_oeB     (rf_oeB),
    .rf_dA      (rf_dA),
    .rf_dB      (rf_dB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] oh(input logic [2:0] i);
    logic [7:0] v;
    v    = 8'h00;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [2:0] enc(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) if (v[i]) r = 3'(i);
    return r;
  endfunction

  // Register file model: tri-state reads, loads on the rising edge.
  assign rf_dA = (rf_oeA != 8'h00) ? phys[enc(rf_oeA)] : 16'hzzzz;
  assign rf_dB = (rf_oeB != 8'h00) ? phys[enc(rf_oeB)] : 16'hzzzz;

  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) if (rf_load[i]) phys[i] <= rf_din;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_regs();
    for (int i = 0; i < 8; i++) check("reg_contents", 32'(phys[i]), 32'(mreg[i]));
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_load"}, 32'(rf_load), 32'd0);
    check({tag, "_oeA"}, 32'(rf_oeA), 32'd0);
    check({tag, "_oeB"}, 32'(rf_oeB), 32'd0);
    check({tag, "_din"}, 32'(rf_din), 32'd0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
  endtask

  task automatic drive(input int id, input logic v, input logic [1:0] op,
                       input logic [2:0] rd, input logic [2:0] rs, input logic [15:0] d);
    if (id == 0) begin
      req0_valid = v; req0_op = op; req0_rd = rd; req0_rs = rs; req0_data = d;
    end else begin
      req1_valid = v; req1_op = op; req1_rd = rd; req1_rs = rs; req1_data = d;
    end
  endtask

  // Command semantics applied to the abstract register array.
  task automatic model_apply(input logic [1:0] op, input logic [2:0] rd,
                             input logic [2:0] rs, input logic [15:0] d);
    logic [15:0] a, b;
    a = mreg[rs];
    b = mreg[rd];
    case (op)
      2'b00: mreg[rd] = d;
      2'b10: mreg[rd] = a;
      2'b11: begin mreg[rd] = a; mreg[rs] = b; end
      default: ;
    endcase
  endtask

  // Issue one command from a lone requester; starts and ends on a falling edge.
  task automatic do_cmd(input int id, input logic [1:0] op, input logic [2:0] rd,
                        input logic [2:0] rs, input logic [15:0] d);
    logic [15:0] old_rs, old_rd, exp_rsp, exp_din;
    logic [7:0]  exp_load, exp_oa, exp_ob;
    int          lat, w;
    logic        rdy;
    old_rs = mreg[rs];
    old_rd = mreg[rd];
    case (op)
      2'b00:   begin lat = 2; exp_rsp = d;      end
      2'b01:   begin lat = 2; exp_rsp = old_rs; end
      2'b10:   begin lat = 3; exp_rsp = old_rs; end
      default: begin lat = 4; exp_rsp = old_rd; end
    endcase
    drive(id, 1'b1, op, rd, rs, d);
    #1;
    w = 0;
    rdy = (id == 0) ? req0_ready : req1_ready;
    while (!rdy && w < 20) begin
      @(negedge clk); #1; w++;
      rdy = (id == 0) ? req0_ready : req1_ready;
    end
    check("accept_ready", 32'(rdy), 32'd1);
    if (!rdy) begin
      drive(id, 1'b0, op, rd, rs, d);
      @(negedge clk);
      return;
    end
    @(posedge clk); #1;
    drive(id, 1'b0, op, rd, rs, d);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      exp_load = 8'h00; exp_din = 16'h0000; exp_oa = 8'h00; exp_ob = 8'h00;
      if (op == 2'b00) begin
        if (k == 1) begin exp_load = oh(rd); exp_din = d; end
      end else begin
        if (k == 1) begin exp_oa = oh(rs); exp_ob = oh(rd); end
        if (k == 2 && op != 2'b01) begin exp_load = oh(rd); exp_din = old_rs; end
        if (k == 3 && op == 2'b11) begin exp_load = oh(rs); exp_din = old_rd; end
      end
      check("cyc_load", 32'(rf_load), 32'(exp_load));
      check("cyc_din", 32'(rf_din), 32'(exp_din));
      check("cyc_oeA", 32'(rf_oeA), 32'(exp_oa));
      check("cyc_oeB", 32'(rf_oeB), 32'(exp_ob));
      check("cyc_busy", 32'(busy), 32'd1);
      check("cyc_no_ready", 32'(req0_ready | req1_ready), 32'd0);
      check("cyc_rsp_valid", 32'(rsp_valid), 32'(k == lat));
    end
    check("rsp_id", 32'(rsp_id), 32'(id));
    check("rsp_data", 32'(rsp_data), 32'(exp_rsp));
    model_apply(op, rd, rs, d);
    @(negedge clk);
    check("post_busy", 32'(busy), 32'd0);
    check("post_rsp_valid", 32'(rsp_valid), 32'd0);
    check_regs();
  endtask

  initial begin : main
    int          w, g, exp_g;
    logic [15:0] old_a, old_b;
    for (int i = 0; i < 8; i++) mreg[i] = 16'h0000;
    rst = 1'b0;
    drive(0, 1'b0, 2'b00, 3'd0, 3'd0, 16'h0);
    drive(1, 1'b0, 2'b00, 3'd0, 3'd0, 16'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    check("reset_rsp_id", 32'(rsp_id), 32'd0);
    check("reset_rsp_data", 32'(rsp_data), 32'd0);
    check("reset_ready", 32'(req0_ready | req1_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Directed WRITE/READ, MOVE, SWAP, self-SWAP.
    do_cmd(0, 2'b00, 3'd3, 3'd0, 16'hBEEF);
    do_cmd(0, 2'b01, 3'd0, 3'd3, 16'h0000);
    do_cmd(1, 2'b00, 3'd1, 3'd0, 16'h1234);
    do_cmd(0, 2'b10, 3'd6, 3'd1, 16'h0000);
    do_cmd(0, 2'b00, 3'd2, 3'd0, 16'hAAAA);
    do_cmd(1, 2'b00, 3'd5, 3'd0, 16'h5555);
    do_cmd(0, 2'b11, 3'd2, 3'd5, 16'h0000);
    do_cmd(1, 2'b00, 3'd4, 3'd0, 16'h4C4C);
    do_cmd(1, 2'b11, 3'd4, 3'd4, 16'h0000);
    do_cmd(1, 2'b10, 3'd7, 3'd7, 16'h0000);

    // Random single-requester traffic.
    for (int n = 0; n < 40; n++) begin
      do_cmd(int'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 16'($urandom));
    end

    // Reset during the WR1 cycle of a SWAP: R[rd] gets written, R[rs] does not.
    do_cmd(0, 2'b00, 3'd0, 3'd0, 16'h0F0F);
    do_cmd(0, 2'b00, 3'd7, 3'd0, 16'h7E7E);
    drive(0, 1'b1, 2'b11, 3'd0, 3'd7, 16'h0000);
    #1;
    check("rst_swap_ready", 32'(req0_ready), 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_swap_wr1_load", 32'(rf_load), 32'(oh(3'd0)));
    rst = 1'b0;
    mreg[0] = mreg[7];
    @(negedge clk);
    check_quiet("midrst1");
    check("midrst_rsp_data", 32'(rsp_data), 32'd0);
    @(negedge clk);
    check_quiet("midrst2");
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("after_rst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    check_regs();

    // Arbitration: both requesters valid, grants must alternate starting with 0.
    drive(0, 1'b1, 2'b00, 3'd1, 3'd0, 16'hA0A0);
    drive(1, 1'b1, 2'b00, 3'd2, 3'd0, 16'hB1B1);
    exp_g = 0;
    for (int n = 0; n < 4; n++) begin
      #1;
      w = 0;
      while (!(req0_ready | req1_ready) && w < 10) begin
        @(negedge clk); #1; w++;
      end
      check("arb_some_ready", 32'(req0_ready | req1_ready), 32'd1);
      check("arb_one_ready", 32'(req0_ready & req1_ready), 32'd0);
      g = req1_ready ? 1 : 0;
      check("arb_grant", 32'(g), 32'(exp_g));
      @(posedge clk);
      @(negedge clk);
      check("arb_wr1_no_ready", 32'(req0_ready | req1_ready), 32'd0);
      @(negedge clk);
      check("arb_rsp_valid", 32'(rsp_valid), 32'd1);
      check("arb_rsp_id", 32'(rsp_id), 32'(exp_g));
      check("arb_rsp_data", 32'(rsp_data), (exp_g == 0) ? 32'h0000A0A0 : 32'h0000B1B1);
      check("arb_rsp_no_ready", 32'(req0_ready | req1_ready), 32'd0);
      exp_g = 1 - exp_g;
      @(negedge clk);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    mreg[1] = 16'hA0A0;
    mreg[2] = 16'hB1B1;
    @(negedge clk);
    check_regs();

    // Stall: req1 waits through a req0 SWAP, then is taken with its held fields.
    old_a = mreg[3];
    old_b = mreg[6];
    drive(0, 1'b1, 2'b11, 3'd3, 3'd6, 16'h0000);
    drive(1, 1'b1, 2'b00, 3'd5, 3'd0, 16'hC3C3);
    #1;
    check("stall_r0_ready", 32'(req0_ready), 32'd1);
    check("stall_r1_wait", 32'(req1_ready), 32'd0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("stall_r1_held", 32'(req1_ready), 32'd0);
      check("stall_rsp_valid", 32'(rsp_valid), 32'(k == 4));
    end
    check("stall_swap_id", 32'(rsp_id), 32'd0);
    check("stall_swap_data", 32'(rsp_data), 32'(old_a));
    mreg[3] = old_b;
    mreg[6] = old_a;
    @(negedge clk); #1;
    check("stall_r1_ready", 32'(req1_ready), 32'd1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    @(negedge clk);
    check("stall_wr_load", 32'(rf_load), 32'(oh(3'd5)));
    @(negedge clk);
    check("stall_wr_rsp_valid", 32'(rsp_valid), 32'd1);
    check("stall_wr_rsp_id", 32'(rsp_id), 32'd1);
    check("stall_wr_rsp_data", 32'(rsp_data), 32'h0000C3C3);
    mreg[5] = 16'hC3C3;
    @(negedge clk);
    check_regs();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
